muldiv_ctrl: RTL and testbench
==============================

# muldiv_ctrl

Sequential execute-stage controller for the MIPS core. It decodes opcode/funct into the 4-bit ALU operation code consumed by the ALU, including shift-source and overflow-check qualifiers. It also owns the HI/LO registers and runs an iterative 32-cycle multiply/divide engine. While that engine is busy, a stall interlock holds back any HI/LO-touching instruction.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is supported
- ITER, 32, iterations per multiply/divide

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- valid_in  in  1  instruction in execute is valid
- opcode  in  6  instruction[31:26]
- funct  in  6  instruction[5:0]
- rs_val  in  32  rs operand
- rt_val  in  32  rt operand
- alu_ctrl  out  4  ALU op: ADD 0000, ADDU 0001, SUB 0010, SUBU 0011, AND 0100, OR 0101, NOR 0110, XOR 0111, SLT 1000, SLTU 1001, SLL 1010, SRL 1011, SRA 1100, LUI 1101
- shamt_sel  out  1  ALU A port takes instruction shamt (sll/srl/sra)
- ovf_chk  out  1  overflow trap enabled (add/sub/addi)
- hilo_rd  out  1  writeback selects hilo_data (mfhi/mflo)
- hilo_data  out  32  HI or LO per funct
- illegal  out  1  unrecognised encoding
- busy  out  1  engine iterating
- stall  out  1  hold PC/pipeline this cycle

## Operation
- Decode is combinational and is gated by valid_in; when valid_in=0, all qualifiers are 0 and alu_ctrl=ADDU.
- R-type (opcode 0) funct-to-alu_ctrl mapping:
  - 20 ADD, 21 ADDU, 22 SUB, 23 SUBU
  - 24 AND, 25 OR, 26 XOR, 27 NOR
  - 2A SLT, 2B SLTU
  - 00 SLL, 02 SRL, 03 SRA (shamt_sel=1)
  - 04 SLLV, 06 SRLV, 07 SRAV (shamt_sel=0)
- I-type opcode-to-alu_ctrl mapping:
  - 08 ADD, 09 ADDU, 0A SLT, 0B SLTU
  - 0C AND, 0D OR, 0E XOR, 0F LUI
  - 23/2B ADDU
  - 04/05 SUBU
- HI/LO funct codes: 10 mfhi, 12 mflo, 11 mthi, 13 mtlo, 18 mult, 19 multu, 1A div, 1B divu. For these, alu_ctrl=ADDU.
- Any other encoding gives illegal=1 and alu_ctrl=ADDU.
- FSM states: IDLE, MUL, DIV.
  - IDLE→MUL/DIV on an accepted mult*/div* (valid_in & ~stall). rs_val/rt_val are latched at that edge and the iteration counter is loaded.
  - MUL/DIV→IDLE when the counter reaches ITER-1. HI/LO are written on that same edge.
- Multiply: shift-add over operand magnitudes. For signed mult, the 64-bit product is negated if the operand signs differ. {HI,LO}=product.
- Divide: restoring division over magnitudes. LO=quotient, HI=remainder. Signed: quotient is negated if signs differ; remainder takes the dividend's sign.
- Divide by zero: LO=FFFF_FFFF, HI=dividend.
- mthi/mtlo write rt_val to HI/LO at the edge when accepted.
- stall = valid_in & busy & (funct is any HI/LO op, opcode 0). Non-HI/LO instructions are never stalled.

## Timing
- Reset values: HI=0, LO=0, busy=0, stall=0, state IDLE. Decode outputs follow their inputs.
- mult/div issued in cycle 0: busy=1 in cycles 1..32, and HI/LO hold the new value from cycle 33.
- An mflo presented in cycle 1..32 stalls; the same mflo presented in cycle 33 reads the new value without stall.
- Back-to-back mult in cycle 1 is stalled until cycle 33, then accepted.
- Reset asserted mid-operation aborts immediately. HI/LO clear and the latched operands are discarded.
- hilo_data is combinational from the HI/LO registers, with no bypass of same-cycle mthi/mtlo.

## Configuration
- MULDIV_EN defined: FSM, engine, HI/LO and stall are present as above.
- MULDIV_EN undefined:
  - funct 10-13 and 18-1B decode as illegal=1.
  - busy=stall=0; hilo_data=0; hilo_rd=0.
  - No HI/LO state is synthesised.

## Structure
- Shared package holds:
  - the 4-bit ALU op constants (shared with the ALU)
  - opcode/funct localparams
  - the FSM state enum
- One sub-module, muldiv_iter: latched operands in, start, signed flag, mul/div select; outputs done, hi, lo. The decoder and interlock stay in the top.

## Test plan
- R-type add (funct 20): alu_ctrl=0000, ovf_chk=1, illegal=0. sll (funct 00): alu_ctrl=1010, shamt_sel=1.
- mult rs=FFFF_FFFE (-2), rt=0000_0003: 33 cycles later HI=FFFF_FFFF, LO=FFFF_FFFA. multu with the same operands gives HI=0000_0002, LO=FFFF_FFFA.
- div rs=FFFF_FFF9 (-7), rt=2: LO=FFFF_FFFD, HI=FFFF_FFFF. divu 7/0: LO=FFFF_FFFF, HI=0000_0007.
- mflo issued in cycle 5 after mult: stall=1 through cycle 32 and 0 in cycle 33 with the product on hilo_data. An addu issued during busy gives stall=0.
- rst_n low in cycle 10 of a div: busy=0 and HI=LO=0 immediately. The next mflo returns 0.
- opcode 3F: illegal=1, alu_ctrl=0001. With MULDIV_EN undefined, funct 18 gives illegal=1 and stall=0.

Source files
------------

// File: rtl/muldiv_ctrl_pkg.sv
// muldiv_ctrl_pkg
// Shared definitions for the execute-stage controller and the ALU:
//   - 4-bit ALU operation codes (consumed by the ALU)
//   - MIPS opcode / funct encodings recognised by the decoder
//   - multiply/divide FSM state encoding
package muldiv_ctrl_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_ADDU = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_SUBU = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_NOR  = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_SLL  = 4'b1010;
  localparam logic [3:0] ALU_SRL  = 4'b1011;
  localparam logic [3:0] ALU_SRA  = 4'b1100;
  localparam logic [3:0] ALU_LUI  = 4'b1101;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_SLLV  = 6'h04;
  localparam logic [5:0] F_SRLV  = 6'h06;
  localparam logic [5:0] F_SRAV  = 6'h07;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter
// Iterative 32-step multiply / divide datapath. Only built when MULDIV_EN
// is defined.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (control only)
//   start           load operands and begin iterating
//   is_signed       treat a/b as two's complement
//   is_div          1 = restoring divide, 0 = shift-add multiply
//   a, b            operands (dividend/divisor for divide), sampled at start
//   done            final iteration this cycle; hi/lo are valid
//   hi, lo          result: product {hi,lo} or remainder/quotient
`ifdef MULDIV_EN
module muldiv_iter
  import muldiv_ctrl_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            is_signed,
  input  logic            is_div,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(ITER);

  function automatic logic [XLEN-1:0] cneg(input logic neg, input logic [XLEN-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cneg2(input logic neg, input logic [2*XLEN-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

  logic            running;
  logic [CW-1:0]   cnt;
  logic            div_q, neg_q, sa_q, dz_q;
  logic [XLEN-1:0] mag, dvd_raw;
  // Multiply: {partial product high, multiplier shifting out low}.
  // Divide:   {partial remainder, dividend shifting in quotient bits}.
  logic [2*XLEN-1:0] acc, acc_nxt;
  logic [XLEN:0]     sum, shl;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_abs, b_abs;

  assign a_neg = is_signed & a[XLEN-1];
  assign b_neg = is_signed & b[XLEN-1];
  assign a_abs = cneg(a_neg, a);
  assign b_abs = cneg(b_neg, b);
  assign done  = running & (cnt == CW'(ITER - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      cnt     <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
    end else if (running) begin
      cnt <= cnt + 1'b1;
      if (done) running <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      div_q   <= is_div;
      neg_q   <= a_neg ^ b_neg;
      sa_q    <= a_neg;
      dz_q    <= (b == '0);
      dvd_raw <= a;
      mag     <= is_div ? b_abs : a_abs;
      acc     <= {{XLEN{1'b0}}, (is_div ? a_abs : b_abs)};
    end else if (running) begin
      acc <= acc_nxt;
    end
  end

  always_comb begin
    acc_nxt = acc;
    sum     = '0;
    shl     = '0;
    if (div_q) begin
      shl = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
      if (shl >= {1'b0, mag}) begin
        sum     = shl - {1'b0, mag};
        acc_nxt = {sum[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      end else begin
        acc_nxt = {shl[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      end
    end else begin
      sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag} : {(XLEN+1){1'b0}});
      acc_nxt = {sum, acc[XLEN-1:1]};
    end
  end

  // Results are taken from the final step directly so they can be written on
  // the done edge without an extra cycle.
  logic [2*XLEN-1:0] prod;
  always_comb begin
    prod = cneg2(neg_q, acc_nxt);
    hi   = prod[2*XLEN-1:XLEN];
    lo   = prod[XLEN-1:0];
    if (div_q) begin
      if (dz_q) begin
        lo = '1;
        hi = dvd_raw;
      end else begin
        lo = cneg(neg_q, acc_nxt[XLEN-1:0]);
        hi = cneg(sa_q, acc_nxt[2*XLEN-1:XLEN]);
      end
    end
  end

endmodule
`endif

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl
// Execute-stage controller: decodes opcode/funct into the ALU op code and
// qualifiers, owns HI/LO and the iterative multiply/divide engine, and
// stalls HI/LO instructions while the engine is busy.
// Optional feature macro: MULDIV_EN (engine, HI/LO, stall). When undefined,
// HI/LO instructions decode as illegal and busy/stall/hilo outputs are 0.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   valid_in          instruction in execute is valid
//   opcode, funct     instruction[31:26], instruction[5:0]
//   rs_val, rt_val    register operands
//   alu_ctrl          ALU operation code
//   shamt_sel         ALU A port takes instruction shamt
//   ovf_chk           overflow trap enabled
//   hilo_rd           writeback selects hilo_data
//   hilo_data         HI (mfhi) or LO (otherwise)
//   illegal           unrecognised encoding
//   busy              engine iterating
//   stall             hold PC/pipeline this cycle
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_in,
  input  logic [5:0]      opcode,
  input  logic [5:0]      funct,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  output logic [3:0]      alu_ctrl,
  output logic            shamt_sel,
  output logic            ovf_chk,
  output logic            hilo_rd,
  output logic [XLEN-1:0] hilo_data,
  output logic            illegal,
  output logic            busy,
  output logic            stall
);

  always_comb begin
    alu_ctrl  = ALU_ADDU;
    shamt_sel = 1'b0;
    ovf_chk   = 1'b0;
    hilo_rd   = 1'b0;
    illegal   = 1'b0;
    if (valid_in) begin
      if (opcode == OP_RTYPE) begin
        case (funct)
          F_ADD:  begin alu_ctrl = ALU_ADD; ovf_chk = 1'b1; end
          F_ADDU: alu_ctrl = ALU_ADDU;
          F_SUB:  begin alu_ctrl = ALU_SUB; ovf_chk = 1'b1; end
          F_SUBU: alu_ctrl = ALU_SUBU;
          F_AND:  alu_ctrl = ALU_AND;
          F_OR:   alu_ctrl = ALU_OR;
          F_XOR:  alu_ctrl = ALU_XOR;
          F_NOR:  alu_ctrl = ALU_NOR;
          F_SLT:  alu_ctrl = ALU_SLT;
          F_SLTU: alu_ctrl = ALU_SLTU;
          F_SLL:  begin alu_ctrl = ALU_SLL; shamt_sel = 1'b1; end
          F_SRL:  begin alu_ctrl = ALU_SRL; shamt_sel = 1'b1; end
          F_SRA:  begin alu_ctrl = ALU_SRA; shamt_sel = 1'b1; end
          F_SLLV: alu_ctrl = ALU_SLL;
          F_SRLV: alu_ctrl = ALU_SRL;
          F_SRAV: alu_ctrl = ALU_SRA;
`ifdef MULDIV_EN
          F_MFHI, F_MFLO: hilo_rd = 1'b1;
          F_MTHI, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU: begin end
`endif
          default: illegal = 1'b1;
        endcase
      end else begin
        case (opcode)
          OP_ADDI:      begin alu_ctrl = ALU_ADD; ovf_chk = 1'b1; end
          OP_ADDIU:     alu_ctrl = ALU_ADDU;
          OP_SLTI:      alu_ctrl = ALU_SLT;
          OP_SLTIU:     alu_ctrl = ALU_SLTU;
          OP_ANDI:      alu_ctrl = ALU_AND;
          OP_ORI:       alu_ctrl = ALU_OR;
          OP_XORI:      alu_ctrl = ALU_XOR;
          OP_LUI:       alu_ctrl = ALU_LUI;
          OP_LW, OP_SW: alu_ctrl = ALU_ADDU;
          OP_BEQ, OP_BNE: alu_ctrl = ALU_SUBU;
          default:      illegal = 1'b1;
        endcase
      end
    end
  end

`ifdef MULDIV_EN
  state_t          state, state_nxt;
  logic            r_type, is_mfhi, is_mflo, is_mthi, is_mtlo, is_md, hilo_op;
  logic            start, done;
  logic [XLEN-1:0] hi_reg, lo_reg, it_hi, it_lo;

  assign r_type  = (opcode == OP_RTYPE);
  assign is_mfhi = r_type & (funct == F_MFHI);
  assign is_mflo = r_type & (funct == F_MFLO);
  assign is_mthi = r_type & (funct == F_MTHI);
  assign is_mtlo = r_type & (funct == F_MTLO);
  assign is_md   = r_type & ((funct == F_MULT) | (funct == F_MULTU) |
                             (funct == F_DIV)  | (funct == F_DIVU));
  assign hilo_op = is_mfhi | is_mflo | is_mthi | is_mtlo | is_md;

  assign busy      = (state != ST_IDLE);
  assign stall     = valid_in & busy & hilo_op;
  // A mult/div while busy is itself stalled, so acceptance reduces to ~busy.
  assign start     = valid_in & ~busy & is_md;
  assign hilo_data = (funct == F_MFHI) ? hi_reg : lo_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:        if (start) state_nxt = funct[1] ? ST_DIV : ST_MUL;
      ST_MUL, ST_DIV: if (done)  state_nxt = ST_IDLE;
      default:        state_nxt = ST_IDLE;
    endcase
  end

  // mthi/mtlo are stalled while busy, so they never collide with done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_reg <= '0;
      lo_reg <= '0;
    end else if (done) begin
      hi_reg <= it_hi;
      lo_reg <= it_lo;
    end else if (valid_in & ~stall) begin
      if (is_mthi) hi_reg <= rt_val;
      if (is_mtlo) lo_reg <= rt_val;
    end
  end

  muldiv_iter #(.XLEN(XLEN), .ITER(ITER)) u_iter (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (~funct[0]),
    .is_div    (funct[1]),
    .a         (rs_val),
    .b         (rt_val),
    .done      (done),
    .hi        (it_hi),
    .lo        (it_lo)
  );
`else
  localparam int unused_iter = ITER;
  logic unused_ports;
  assign unused_ports = ^{clk, rst_n, rs_val, rt_val};
  assign busy      = 1'b0;
  assign stall     = 1'b0;
  assign hilo_data = '0;
`endif

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, valid_in;
  logic [5:0]  opcode, funct;
  logic [31:0] rs_val, rt_val;
  logic [3:0]  alu_ctrl;
  logic        shamt_sel, ovf_chk, hilo_rd, illegal, busy, stall;
  logic [31:0] hilo_data;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_ctrl dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .opcode(opcode), .funct(funct),
    .rs_val(rs_val), .rt_val(rt_val), .alu_ctrl(alu_ctrl), .shamt_sel(shamt_sel),
    .ovf_chk(ovf_chk), .hilo_rd(hilo_rd), .hilo_data(hilo_data), .illegal(illegal),
    .busy(busy), .stall(stall)
  );

  task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                       input logic [31:0] rs, input logic [31:0] rt);
    valid_in = v; opcode = op; funct = fn; rs_val = rs; rt_val = rt;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(1'b0, 6'h00, 6'h12, 32'h0, 32'h0);
    #1;
    checks++; if ({busy, stall} !== 2'b00) begin errors++; $display("FAIL reset_busy_stall: got %b want 00", {busy, stall}); end
    checks++; if (hilo_data !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 00000000", hilo_data); end
    funct = 6'h10; #1;
    checks++; if (hilo_data !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 00000000", hilo_data); end
    tick; tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_decode;
    logic [5:0] ops [15] = '{6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,6'h08,6'h0F,6'h04,6'h2B,6'h3F,6'h00,6'h0E,6'h00};
    logic [5:0] fns [15] = '{6'h20,6'h00,6'h04,6'h27,6'h26,6'h2B,6'h03,6'h00,6'h00,6'h00,6'h00,6'h00,6'h01,6'h00,6'h22};
    // {alu_ctrl, shamt_sel, ovf_chk, illegal}
    logic [6:0] exp [15] = '{7'b0000010,7'b1010100,7'b1010000,7'b0110000,7'b0111000,
                             7'b1001000,7'b1100100,7'b0000010,7'b1101000,7'b0011000,
                             7'b0001000,7'b0001001,7'b0001001,7'b0111000,7'b0010010};
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, ops[i], fns[i], 32'h0, 32'h0);
      #1;
      checks++;
      if ({alu_ctrl, shamt_sel, ovf_chk, illegal} !== exp[i]) begin
        errors++;
        $display("FAIL decode op=%h fn=%h: got %b want %b", ops[i], fns[i],
                 {alu_ctrl, shamt_sel, ovf_chk, illegal}, exp[i]);
      end
    end
    drive(1'b0, 6'h00, 6'h20, 32'h0, 32'h0);
    #1;
    checks++;
    if ({alu_ctrl, shamt_sel, ovf_chk, illegal, hilo_rd} !== 8'b00010000) begin
      errors++;
      $display("FAIL decode_invalid: got %b want 00010000", {alu_ctrl, shamt_sel, ovf_chk, illegal, hilo_rd});
    end
  endtask

`ifdef MULDIV_EN
  // Issues in cycle 0 and returns in cycle 33 with inputs idle.
  task automatic issue_and_wait(input logic [5:0] fn, input logic [31:0] rs, input logic [31:0] rt);
    tick;
    drive(1'b1, 6'h00, fn, rs, rt);
    tick;
    drive(1'b0, 6'h00, 6'h00, 32'h0, 32'h0);
    repeat (32) tick;
  endtask

  task automatic test_mult;
    tick;
    drive(1'b1, 6'h00, 6'h18, 32'hFFFF_FFFE, 32'h0000_0003);
    @(negedge clk);
    checks++; if ({stall, illegal} !== 2'b00) begin errors++; $display("FAIL mult_issue: got %b want 00", {stall, illegal}); end
    tick;
    drive(1'b1, 6'h00, 6'h21, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if ({busy, stall} !== 2'b10) begin errors++; $display("FAIL addu_during_busy: got %b want 10", {busy, stall}); end
    for (int c = 2; c < 5; c++) begin
      tick;
      drive(1'b0, 6'h00, 6'h00, 32'h0, 32'h0);
    end
    for (int c = 5; c <= 32; c++) begin
      tick;
      drive(1'b1, 6'h00, 6'h12, 32'h0, 32'h0);
      @(negedge clk);
      checks++; if ({busy, stall} !== 2'b11) begin errors++; $display("FAIL mflo_stall c%0d: got %b want 11", c, {busy, stall}); end
    end
    tick;
    @(negedge clk);
    checks++; if ({busy, stall, hilo_rd} !== 3'b001) begin errors++; $display("FAIL mflo_c33_flags: got %b want 001", {busy, stall, hilo_rd}); end
    checks++; if (hilo_data !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo: got %h want FFFFFFFA", hilo_data); end
    drive(1'b1, 6'h00, 6'h10, 32'h0, 32'h0);
    #1;
    checks++; if (hilo_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h want FFFFFFFF", hilo_data); end
    drive(1'b0, 6'h00, 6'h00, 32'h0, 32'h0);
  endtask

  task automatic test_multu_div;
    issue_and_wait(6'h19, 32'hFFFF_FFFE, 32'h0000_0003);
    funct = 6'h12; #1;
    checks++; if (hilo_data !== 32'hFFFF_FFFA) begin errors++; $display("FAIL multu_lo: got %h want FFFFFFFA", hilo_data); end
    funct = 6'h10; #1;
    checks++; if (hilo_data !== 32'h0000_0002) begin errors++; $display("FAIL multu_hi: got %h want 00000002", hilo_data); end
    issue_and_wait(6'h1A, 32'hFFFF_FFF9, 32'h0000_0002);
    funct = 6'h12; #1;
    checks++; if (hilo_data !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo: got %h want FFFFFFFD", hilo_data); end
    funct = 6'h10; #1;
    checks++; if (hilo_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi: got %h want FFFFFFFF", hilo_data); end
    issue_and_wait(6'h1B, 32'h0000_0007, 32'h0000_0000);
    funct = 6'h12; #1;
    checks++; if (hilo_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu0_lo: got %h want FFFFFFFF", hilo_data); end
    funct = 6'h10; #1;
    checks++; if (hilo_data !== 32'h0000_0007) begin errors++; $display("FAIL divu0_hi: got %h want 00000007", hilo_data); end
    issue_and_wait(6'h1B, 32'h0000_0064, 32'h0000_0007);
    funct = 6'h12; #1;
    checks++; if (hilo_data !== 32'h0000_000E) begin errors++; $display("FAIL divu_lo: got %h want 0000000E", hilo_data); end
    funct = 6'h10; #1;
    checks++; if (hilo_data !== 32'h0000_0002) begin errors++; $display("FAIL divu_hi: got %h want 00000002", hilo_data); end
  endtask

  task automatic test_back_to_back;
    tick;
    drive(1'b1, 6'h00, 6'h18, 32'h0000_0003, 32'h0000_0003);
    tick;
    drive(1'b1, 6'h00, 6'h18, 32'h0000_0005, 32'hFFFF_FFFC);
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_stall c%0d: got %b want 1", c, stall); end
      tick;
    end
    @(negedge clk);
    checks++; if ({busy, stall} !== 2'b00) begin errors++; $display("FAIL b2b_c33: got %b want 00", {busy, stall}); end
    checks++; if (hilo_data !== 32'h0000_0009) begin errors++; $display("FAIL b2b_first_lo: got %h want 00000009", hilo_data); end
    tick;
    drive(1'b0, 6'h00, 6'h00, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_second_busy: got %b want 1", busy); end
    repeat (32) tick;
    funct = 6'h12; #1;
    checks++; if (hilo_data !== 32'hFFFF_FFEC) begin errors++; $display("FAIL b2b_second_lo: got %h want FFFFFFEC", hilo_data); end
    funct = 6'h10; #1;
    checks++; if (hilo_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL b2b_second_hi: got %h want FFFFFFFF", hilo_data); end
  endtask

  task automatic test_mthi_mtlo;
    tick;
    drive(1'b1, 6'h00, 6'h11, 32'h0, 32'h1234_5678);
    tick;
    drive(1'b1, 6'h00, 6'h13, 32'h0, 32'hCAFE_F00D);
    #1;
    checks++; if (hilo_data !== 32'hFFFF_FFEC) begin errors++; $display("FAIL mtlo_no_bypass: got %h want FFFFFFEC", hilo_data); end
    tick;
    drive(1'b1, 6'h00, 6'h10, 32'h0, 32'h0);
    #1;
    checks++; if (hilo_data !== 32'h1234_5678) begin errors++; $display("FAIL mthi: got %h want 12345678", hilo_data); end
    funct = 6'h12; #1;
    checks++; if (hilo_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL mtlo: got %h want CAFEF00D", hilo_data); end
    drive(1'b0, 6'h00, 6'h00, 32'h0, 32'h0);
  endtask

  task automatic test_reset_mid;
    tick;
    drive(1'b1, 6'h00, 6'h1A, 32'h0000_0064, 32'h0000_0003);
    tick;
    drive(1'b0, 6'h00, 6'h12, 32'h0, 32'h0);
    repeat (9) tick;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    checks++; if (hilo_data !== 32'h0) begin errors++; $display("FAIL rstmid_lo: got %h want 00000000", hilo_data); end
    funct = 6'h10; #1;
    checks++; if (hilo_data !== 32'h0) begin errors++; $display("FAIL rstmid_hi: got %h want 00000000", hilo_data); end
    tick;
    rst_n = 1'b1;
    tick;
    drive(1'b1, 6'h00, 6'h12, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if ({stall, hilo_data} !== 33'h0) begin errors++; $display("FAIL rstmid_next_mflo: got %b/%h want 0/00000000", stall, hilo_data); end
    repeat (40) tick;
    checks++; if ({busy, hilo_data} !== 33'h0) begin errors++; $display("FAIL rstmid_discarded: got %b/%h want 0/00000000", busy, hilo_data); end
    drive(1'b0, 6'h00, 6'h00, 32'h0, 32'h0);
  endtask
`else
  task automatic test_disabled;
    tick;
    drive(1'b1, 6'h00, 6'h18, 32'h0000_0005, 32'h0000_0003);
    #1;
    checks++; if ({alu_ctrl, illegal, stall} !== 6'b000110) begin errors++; $display("FAIL dis_mult_decode: got %b want 000110", {alu_ctrl, illegal, stall}); end
    tick;
    checks++; if ({busy, stall} !== 2'b00) begin errors++; $display("FAIL dis_busy: got %b want 00", {busy, stall}); end
    drive(1'b1, 6'h00, 6'h10, 32'h0, 32'h0);
    #1;
    checks++; if ({illegal, hilo_rd} !== 2'b10) begin errors++; $display("FAIL dis_mfhi: got %b want 10", {illegal, hilo_rd}); end
    drive(1'b1, 6'h00, 6'h13, 32'h0, 32'hFFFF_FFFF);
    tick;
    drive(1'b1, 6'h00, 6'h12, 32'h0, 32'h0);
    #1;
    checks++; if (hilo_data !== 32'h0) begin errors++; $display("FAIL dis_hilo_data: got %h want 00000000", hilo_data); end
    drive(1'b0, 6'h00, 6'h00, 32'h0, 32'h0);
  endtask
`endif

  initial begin
    test_reset;
    test_decode;
`ifdef MULDIV_EN
    test_mult;
    test_multu_div;
    test_back_to_back;
    test_mthi_mtlo;
    test_reset_mid;
`else
    test_disabled;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
